cpu_mc_controller: RTL and testbench
====================================

Name: cpu_mc_controller

Overview:
- Multicycle control FSM for the 5-bit-opcode CPU. It replaces the single-cycle combinational controller and drives a shared instruction/data memory through a req/ready handshake.
- It sequences fetch, decode, execute, memory and writeback over several cycles and stalls on memory latency.
- It flags bus timeouts and illegal opcodes, and halts on a HALT instruction.
- It sits between the CPU top and a multicycle datapath, which holds the IR, the A/B/ALUOut registers and the MDR.

Parameters:
- OPCODE_W, 5: opcode width, taken from instr[31:27].
- ALUCTL_W, 4: aluControl width.
- TIMEOUT, 16: maximum cycles memReq may wait for memReady before a bus error; legal range 1..255.

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- opcode, input, OPCODE_W: IR[31:27]; valid from DECODE onward.
- zero, input, 1: ALU zero flag.
- memReady, input, 1: memory has completed the current access (read data valid, or write accepted).
- memReq, output, 1: memory access request.
- memWrite, output, 1: the access is a write; meaningful only while memReq=1.
- iord, output, 1: address select, 0=PC, 1=ALUOut.
- irWrite, output, 1: load IR.
- pcWrite, output, 1: PC write enable.
- pcSrc, output, 2: PC source, 00=ALU result, 01=ALUOut (branch target), 10=jump target.
- aluSrcA, output, 1: ALU A input, 0=PC, 1=A register.
- aluSrcB, output, 2: ALU B input, 00=B, 01=constant 4, 10=sign-extended immediate, 11=sign-extended immediate shifted left 2.
- aluControl, output, ALUCTL_W: ALU operation.
- regDst, output, 1: destination register select, 1=rd, 0=rt.
- memToReg, output, 1: register writeback source, 1=MDR, 0=ALUOut.
- regWrite, output, 1: register file write enable.
- halted, output, 1: sticky; the core is stopped.
- busError, output, 1: sticky; a memory timeout occurred.
- illegal, output, 1: sticky; an undefined opcode was decoded.

Behaviour:
- Outputs are Moore, decoded from the state register only. Every output not listed for a state is 0.
- ALU codes: ADD=0010, SUB=0110, AND=0000, OR=0001, SLT=0111.
- Opcodes:
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 SLT (R-type).
  - 01000 ADDI, 10000 LW, 10001 SW, 11000 BEQ, 11100 J, 11111 HALT.
  - All other opcodes are illegal.
- Reset: state=S_IDLE; timeout counter=0; halted=busError=illegal=0. In S_IDLE all outputs are 0. S_IDLE always moves to S_FETCH on the next cycle.
- S_FETCH:
  - Drives memReq=1, iord=0, aluSrcA=0, aluSrcB=01, aluControl=ADD.
  - While memReady=0: holds state with irWrite=pcWrite=0.
  - Cycle with memReady=1: irWrite=1 and pcWrite=1 (PC+4), then go to S_DECODE.
  - irWrite and pcWrite are the only outputs gated combinationally by memReady.
- S_DECODE: aluSrcA=0, aluSrcB=11, aluControl=ADD (branch target into ALUOut).
  - R-type goes to S_EXEC.
  - ADDI, LW and SW go to S_MEMADR.
  - BEQ goes to S_BRANCH; J goes to S_JUMP.
  - HALT goes to S_HALT.
  - An illegal opcode sets illegal and goes to S_HALT.
- S_EXEC: aluSrcA=1, aluSrcB=00, aluControl per opcode; go to S_ALUWB.
- S_ALUWB: regWrite=1, regDst=1, memToReg=0; go to S_FETCH.
- S_MEMADR: aluSrcA=1, aluSrcB=10, aluControl=ADD.
  - ADDI goes to S_IMMWB; LW goes to S_MEMRD; SW goes to S_MEMWR.
- S_IMMWB: regWrite=1, regDst=0, memToReg=0; go to S_FETCH.
- S_MEMRD: memReq=1, iord=1; hold until memReady=1, then go to S_MEMWB.
- S_MEMWB: regWrite=1, regDst=0, memToReg=1; go to S_FETCH.
- S_MEMWR: memReq=1, memWrite=1, iord=1; hold until memReady=1, then go to S_FETCH.
- S_BRANCH: aluSrcA=1, aluSrcB=00, aluControl=SUB, pcSrc=01, pcWrite=zero; go to S_FETCH.
- S_JUMP: pcSrc=10, pcWrite=1; go to S_FETCH.
- S_HALT: sets halted. All other outputs are 0; the state is absorbing until reset.
- Timeout counter:
  - Cleared on entry to any memReq state and while memReady=1.
  - Increments each cycle a memReq state waits with memReady=0.
  - When it reaches TIMEOUT while memReady=0: set busError and go to S_HALT. memReq drops the next cycle.
  - memReady=1 on the same cycle the counter reaches TIMEOUT counts as success, not an error.
- memReady outside memReq states is ignored.
- Reset asserted mid-access, including while memReq=1, forces S_IDLE at that edge. memReq is 0 from the next cycle and all sticky flags clear.

Decomposition:
- Package cpu_mc_pkg holds:
  - the state enum;
  - opcode localparams (OP_ADD … OP_HALT);
  - ALU code localparams;
  - the pcSrc and aluSrcB encoding localparams.
- One sub-module, cpu_mc_timeout: a $clog2(TIMEOUT+1)-bit counter with clr/en inputs and an expired output.

Test Plan:
- Reset, then ADD (00000) with memReady returned after 3 wait cycles:
  - Exactly 1 idle cycle, then S_FETCH.
  - memReq held 4 cycles; irWrite/pcWrite pulse only on the memReady cycle.
  - Then DECODE → EXEC (aluControl=0010) → ALUWB with regWrite=1 and regDst=1.
- LW with memReady=1 immediately on both accesses:
  - Sequence FETCH, DECODE, MEMADR, MEMRD (iord=1), MEMWB (memToReg=1, regWrite=1): 5 cycles.
- BEQ with zero=1, then BEQ with zero=0:
  - S_BRANCH shows pcSrc=01 in both cases.
  - pcWrite=1 only in the first case.
- SW with memReady held at 0, TIMEOUT=16:
  - memReq=memWrite=1 for 16 cycles.
  - busError=1 and halted=1 afterwards; memReq=0.
  - Repeat with memReady=1 on the 16th wait cycle: no error, returns to S_FETCH.
- Opcode 00101: illegal=1, halted=1, all control outputs 0 thereafter.
  - Reset clears all flags; the next fetch proceeds normally.
- Reset asserted during S_MEMRD wait:
  - Next cycle in S_IDLE with memReq=0.
  - A late memReady pulse in S_IDLE causes no state change.

Source files
------------

// File: rtl/cpu_mc_pkg.sv
// Shared encodings for the multicycle CPU controller: states, opcodes,
// ALU operation codes and datapath mux selects.
package cpu_mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_ALUWB,
        S_MEMADR,
        S_IMMWB,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_e;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_SLT  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_LW   = 5'b10000;
    localparam logic [4:0] OP_SW   = 5'b10001;
    localparam logic [4:0] OP_BEQ  = 5'b11000;
    localparam logic [4:0] OP_J    = 5'b11100;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // ALU operation for an R-type opcode; non-R-type falls back to ADD.
    function automatic logic [3:0] alu_for(input logic [4:0] op);
        logic [3:0] code;
        code = ALU_ADD;
        case (op)
            OP_SUB:  code = ALU_SUB;
            OP_AND:  code = ALU_AND;
            OP_OR:   code = ALU_OR;
            OP_SLT:  code = ALU_SLT;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cpu_mc_timeout.sv
// Memory wait counter: flags the cycle on which a pending access has
// waited TIMEOUT cycles without memReady.
module cpu_mc_timeout #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // This wait cycle would bring the count to TIMEOUT.
    assign expired_c = en && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_mc_controller.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback
// against a req/ready memory, with sticky halt, bus-error and illegal flags.
module cpu_mc_controller
    import cpu_mc_pkg::*;
#(
    parameter int unsigned OPCODE_W = 5,
    parameter int unsigned ALUCTL_W = 4,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                memReady,
    output logic                memReq,
    output logic                memWrite,
    output logic                iord,
    output logic                irWrite,
    output logic                pcWrite,
    output logic [1:0]          pcSrc,
    output logic                aluSrcA,
    output logic [1:0]          aluSrcB,
    output logic [ALUCTL_W-1:0] aluControl,
    output logic                regDst,
    output logic                memToReg,
    output logic                regWrite,
    output logic                halted,
    output logic                busError,
    output logic                illegal
);

    state_e state;
    state_e state_nxt;
    logic   mem_state_c;
    logic   tmo_expired_c;
    logic   illegal_set_c;

    assign mem_state_c = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

    cpu_mc_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clr       (!mem_state_c || memReady),
        .en        (mem_state_c && !memReady),
        .expired_c (tmo_expired_c)
    );

    // State register and sticky status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            halted   <= 1'b0;
            busError <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt == S_HALT) halted   <= 1'b1;
            if (tmo_expired_c)       busError <= 1'b1;
            if (illegal_set_c)       illegal  <= 1'b1;
        end
    end

    // Next state and Moore control decode.
    always_comb begin
        state_nxt     = state;
        illegal_set_c = 1'b0;
        memReq        = 1'b0;
        memWrite      = 1'b0;
        iord          = 1'b0;
        irWrite       = 1'b0;
        pcWrite       = 1'b0;
        pcSrc         = PCSRC_ALU;
        aluSrcA       = 1'b0;
        aluSrcB       = SRCB_B;
        aluControl    = '0;
        regDst        = 1'b0;
        memToReg      = 1'b0;
        regWrite      = 1'b0;

        case (state)
            S_IDLE: state_nxt = S_FETCH;

            S_FETCH: begin
                memReq     = 1'b1;
                pcSrc      = PCSRC_ALU;
                aluSrcB    = SRCB_FOUR;
                aluControl = ALU_ADD;
                if (memReady) begin
                    irWrite   = 1'b1;
                    pcWrite   = 1'b1;
                    state_nxt = S_DECODE;
                end else if (tmo_expired_c) begin
                    state_nxt = S_HALT;
                end
            end

            S_DECODE: begin
                aluSrcB    = SRCB_IMMSH;
                aluControl = ALU_ADD;
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: state_nxt = S_EXEC;
                    OP_ADDI, OP_LW, OP_SW:                 state_nxt = S_MEMADR;
                    OP_BEQ:                                state_nxt = S_BRANCH;
                    OP_J:                                  state_nxt = S_JUMP;
                    OP_HALT:                               state_nxt = S_HALT;
                    default: begin
                        illegal_set_c = 1'b1;
                        state_nxt     = S_HALT;
                    end
                endcase
            end

            S_EXEC: begin
                aluSrcA    = 1'b1;
                aluSrcB    = SRCB_B;
                aluControl = alu_for(opcode);
                state_nxt  = S_ALUWB;
            end

            S_ALUWB: begin
                regWrite  = 1'b1;
                regDst    = 1'b1;
                state_nxt = S_FETCH;
            end

            S_MEMADR: begin
                aluSrcA    = 1'b1;
                aluSrcB    = SRCB_IMM;
                aluControl = ALU_ADD;
                case (opcode)
                    OP_LW:   state_nxt = S_MEMRD;
                    OP_SW:   state_nxt = S_MEMWR;
                    default: state_nxt = S_IMMWB;
                endcase
            end

            S_IMMWB: begin
                regWrite  = 1'b1;
                state_nxt = S_FETCH;
            end

            S_MEMRD: begin
                memReq = 1'b1;
                iord   = 1'b1;
                if (memReady)           state_nxt = S_MEMWB;
                else if (tmo_expired_c) state_nxt = S_HALT;
            end

            S_MEMWB: begin
                regWrite  = 1'b1;
                memToReg  = 1'b1;
                state_nxt = S_FETCH;
            end

            S_MEMWR: begin
                memReq   = 1'b1;
                memWrite = 1'b1;
                iord     = 1'b1;
                if (memReady)           state_nxt = S_FETCH;
                else if (tmo_expired_c) state_nxt = S_HALT;
            end

            S_BRANCH: begin
                aluSrcA    = 1'b1;
                aluSrcB    = SRCB_B;
                aluControl = ALU_SUB;
                pcSrc      = PCSRC_ALUOUT;
                pcWrite    = zero;
                state_nxt  = S_FETCH;
            end

            S_JUMP: begin
                pcSrc     = PCSRC_JUMP;
                pcWrite   = 1'b1;
                state_nxt = S_FETCH;
            end

            S_HALT: state_nxt = S_HALT;

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_mc_controller.sv
// Directed bench for cpu_mc_controller: a cycle-by-cycle vector table for
// the instruction mix plus hand-written timeout, illegal and reset sequences.
module tb_cpu_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] opcode;
    logic       zero;
    logic       memReady;
    logic       memReq, memWrite, iord, irWrite, pcWrite;
    logic [1:0] pcSrc;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [3:0] aluControl;
    logic       regDst, memToReg, regWrite, halted, busError, illegal;

    cpu_mc_controller #(
        .OPCODE_W (5),
        .ALUCTL_W (4),
        .TIMEOUT  (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .memReady   (memReady),
        .memReq     (memReq),
        .memWrite   (memWrite),
        .iord       (iord),
        .irWrite    (irWrite),
        .pcWrite    (pcWrite),
        .pcSrc      (pcSrc),
        .aluSrcA    (aluSrcA),
        .aluSrcB    (aluSrcB),
        .aluControl (aluControl),
        .regDst     (regDst),
        .memToReg   (memToReg),
        .regWrite   (regWrite),
        .halted     (halted),
        .busError   (busError),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    logic [19:0] act;
    assign act = {memReq, memWrite, iord, irWrite, pcWrite, pcSrc, aluSrcA, aluSrcB,
                  aluControl, regDst, memToReg, regWrite, halted, busError, illegal};

    typedef struct {
        logic [4:0]  op;
        logic        z;
        logic        rdy;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [19:0] F_H  = 20'h4;
    localparam logic [19:0] F_BE = 20'h2;
    localparam logic [19:0] F_IL = 20'h1;

    logic [19:0] E_IDLE, E_FW, E_FR, E_DEC, E_ALUWB, E_MADR, E_IMMWB;
    logic [19:0] E_MRD, E_MWB, E_MWR, E_JMP, E_HALT;

    function automatic logic [19:0] mk(input logic mr, input logic mw, input logic io,
                                       input logic irw, input logic pcw, input logic [1:0] ps,
                                       input logic sa, input logic [1:0] sb, input logic [3:0] ac,
                                       input logic rd, input logic m2r, input logic rw);
        return {mr, mw, io, irw, pcw, ps, sa, sb, ac, rd, m2r, rw, 3'b000};
    endfunction

    function automatic logic [19:0] e_exec(input logic [3:0] ac);
        return mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, ac, 0, 0, 0);
    endfunction

    function automatic logic [19:0] e_br(input logic z);
        return mk(0, 0, 0, 0, z, 2'b01, 1, 2'b00, 4'b0110, 0, 0, 0);
    endfunction

    task automatic push(input logic [4:0] op, input logic z, input logic rdy, input logic [19:0] exp);
        vec_t v;
        v.op = op; v.z = z; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic push_r(input logic [4:0] op, input logic [3:0] ac);
        push(op, 0, 1, E_FR);
        push(op, 0, 0, E_DEC);
        push(op, 0, 0, e_exec(ac));
        push(op, 0, 0, E_ALUWB);
    endtask

    // Drive inputs just after a rising edge, compare on the falling edge.
    task automatic step(input string tag, input int id, input logic [4:0] op,
                        input logic z, input logic rdy, input logic [19:0] exp);
        opcode = op; zero = z; memReady = rdy;
        @(negedge clk);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: outputs got %b required %b", tag, id, act, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; memReady = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        E_IDLE  = 20'h0;
        E_FW    = mk(1, 0, 0, 0, 0, 2'b00, 0, 2'b01, 4'b0010, 0, 0, 0);
        E_FR    = mk(1, 0, 0, 1, 1, 2'b00, 0, 2'b01, 4'b0010, 0, 0, 0);
        E_DEC   = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 4'b0010, 0, 0, 0);
        E_ALUWB = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 4'b0000, 1, 0, 1);
        E_MADR  = mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 4'b0010, 0, 0, 0);
        E_IMMWB = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 4'b0000, 0, 0, 1);
        E_MRD   = mk(1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 4'b0000, 0, 0, 0);
        E_MWB   = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 4'b0000, 0, 1, 1);
        E_MWR   = mk(1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 4'b0000, 0, 0, 0);
        E_JMP   = mk(0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 4'b0000, 0, 0, 0);
        E_HALT  = F_H;

        // ADD with three fetch wait cycles
        push(5'b00000, 0, 1, E_IDLE);
        push(5'b00000, 0, 0, E_FW);
        push(5'b00000, 0, 0, E_FW);
        push(5'b00000, 0, 0, E_FW);
        push(5'b00000, 0, 1, E_FR);
        push(5'b00000, 0, 0, E_DEC);
        push(5'b00000, 0, 0, e_exec(4'b0010));
        push(5'b00000, 0, 0, E_ALUWB);
        // LW, zero-wait
        push(5'b10000, 0, 1, E_FR);
        push(5'b10000, 0, 0, E_DEC);
        push(5'b10000, 0, 0, E_MADR);
        push(5'b10000, 0, 1, E_MRD);
        push(5'b10000, 0, 0, E_MWB);
        // BEQ taken then not taken
        push(5'b11000, 1, 1, E_FR);
        push(5'b11000, 1, 0, E_DEC);
        push(5'b11000, 1, 0, e_br(1'b1));
        push(5'b11000, 0, 1, E_FR);
        push(5'b11000, 0, 0, E_DEC);
        push(5'b11000, 0, 0, e_br(1'b0));
        push_r(5'b00001, 4'b0110);
        push_r(5'b00010, 4'b0000);
        push_r(5'b00011, 4'b0001);
        push_r(5'b00100, 4'b0111);
        // ADDI
        push(5'b01000, 0, 1, E_FR);
        push(5'b01000, 0, 0, E_DEC);
        push(5'b01000, 0, 0, E_MADR);
        push(5'b01000, 0, 0, E_IMMWB);
        // SW zero-wait, with stray memReady outside memory states
        push(5'b10001, 0, 1, E_FR);
        push(5'b10001, 0, 1, E_DEC);
        push(5'b10001, 0, 1, E_MADR);
        push(5'b10001, 0, 1, E_MWR);
        // J
        push(5'b11100, 0, 1, E_FR);
        push(5'b11100, 0, 0, E_DEC);
        push(5'b11100, 0, 0, E_JMP);
        // LW with two read wait cycles
        push(5'b10000, 0, 1, E_FR);
        push(5'b10000, 0, 0, E_DEC);
        push(5'b10000, 0, 0, E_MADR);
        push(5'b10000, 0, 0, E_MRD);
        push(5'b10000, 0, 0, E_MRD);
        push(5'b10000, 0, 1, E_MRD);
        push(5'b10000, 0, 0, E_MWB);
        // HALT is absorbing
        push(5'b11111, 0, 1, E_FR);
        push(5'b11111, 0, 0, E_DEC);
        push(5'b11111, 0, 0, E_HALT);
        push(5'b11111, 0, 1, E_HALT);
        push(5'b00000, 0, 1, E_HALT);

        opcode = '0; zero = 1'b0;
        do_reset();
        for (int i = 0; i < vecs.size(); i++)
            step("table", i, vecs[i].op, vecs[i].z, vecs[i].rdy, vecs[i].exp);

        // SW times out after 16 wait cycles
        do_reset();
        step("sw_to", 0, 5'b10001, 0, 0, E_IDLE);
        step("sw_to", 1, 5'b10001, 0, 1, E_FR);
        step("sw_to", 2, 5'b10001, 0, 0, E_DEC);
        step("sw_to", 3, 5'b10001, 0, 0, E_MADR);
        for (int i = 0; i < 16; i++)
            step("sw_to_wait", i, 5'b10001, 0, 0, E_MWR);
        step("sw_to", 4, 5'b10001, 0, 0, F_H | F_BE);
        step("sw_to", 5, 5'b10001, 0, 1, F_H | F_BE);

        // memReady on the 16th wait cycle still succeeds
        do_reset();
        step("sw_ok", 0, 5'b10001, 0, 0, E_IDLE);
        step("sw_ok", 1, 5'b10001, 0, 1, E_FR);
        step("sw_ok", 2, 5'b10001, 0, 0, E_DEC);
        step("sw_ok", 3, 5'b10001, 0, 0, E_MADR);
        for (int i = 0; i < 15; i++)
            step("sw_ok_wait", i, 5'b10001, 0, 0, E_MWR);
        step("sw_ok", 4, 5'b10001, 0, 1, E_MWR);
        step("sw_ok", 5, 5'b10001, 0, 0, E_FW);

        // Illegal opcode, then reset clears flags and fetch proceeds
        do_reset();
        step("ill", 0, 5'b00101, 0, 0, E_IDLE);
        step("ill", 1, 5'b00101, 0, 1, E_FR);
        step("ill", 2, 5'b00101, 0, 0, E_DEC);
        step("ill", 3, 5'b00101, 0, 0, F_H | F_IL);
        step("ill", 4, 5'b00101, 1, 1, F_H | F_IL);
        do_reset();
        step("ill", 5, 5'b00000, 0, 0, E_IDLE);
        step("ill", 6, 5'b00000, 0, 1, E_FR);
        step("ill", 7, 5'b00000, 0, 0, E_DEC);

        // Reset during a read wait, then a late memReady in IDLE
        do_reset();
        step("rst_rd", 0, 5'b10000, 0, 0, E_IDLE);
        step("rst_rd", 1, 5'b10000, 0, 1, E_FR);
        step("rst_rd", 2, 5'b10000, 0, 0, E_DEC);
        step("rst_rd", 3, 5'b10000, 0, 0, E_MADR);
        step("rst_rd", 4, 5'b10000, 0, 0, E_MRD);
        step("rst_rd", 5, 5'b10000, 0, 0, E_MRD);
        do_reset();
        step("rst_rd", 6, 5'b10000, 0, 1, E_IDLE);
        step("rst_rd", 7, 5'b10000, 0, 0, E_FW);
        step("rst_rd", 8, 5'b10000, 0, 1, E_FR);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
